// File: rtl/cic_dec_var.sv
// Variable-rate (1..255) 4-stage CIC decimator, differential delay 1.
// Gain is normalised by a rate-derived shift with round-half-up and saturation.
module cic_dec_var #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [7:0]       rate,
   input  logic             stb_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             stb_out,
   output logic [WIDTH-1:0] data_out
);

   localparam int IW = WIDTH + 32;
   localparam logic [IW:0] LP_ONE = 1;

   logic [7:0]       r_rate_q;
   logic             r_rate_vld;
   logic [7:0]       r_cnt;
   logic [IW-1:0]    r_int  [4];
   logic [IW-1:0]    r_cin;
   logic [IW-1:0]    r_cdly [4];
   logic [IW-1:0]    r_comb [4];
   logic [5:0]       r_sp;
   logic [IW:0]      r_shf;
   logic             r_stb_out;
   logic [WIDTH-1:0] r_data_out;

   logic [7:0]        w_rate_eff;
   logic              w_flush;
   logic              w_dec;
   logic [3:0]        w_clog;
   logic [5:0]        w_shift;
   logic [IW:0]       w_rnd;
   logic [IW:0]       w_sum;
   logic signed [IW:0] w_shifted;
   logic [WIDTH-1:0]  w_sat;
   logic [IW-1:0]     w_cstage [4];

   function automatic logic [3:0] f_clog2(input logic [7:0] v);
      logic [7:0] m;
      f_clog2 = '0;
      m = v - 8'd1;
      for (int unsigned i = 0; i < 8; i++) begin
         if (m[i]) f_clog2 = 4'(i + 1);
      end
   endfunction

   assign w_rate_eff = (rate == 8'd0) ? 8'd1 : rate;
   // The first edge after reset has no previous rate to compare against.
   assign w_flush    = !enable || (r_rate_vld && (rate != r_rate_q));
   assign w_dec      = stb_in && !w_flush && (r_cnt == (w_rate_eff - 8'd1));
   assign w_clog     = f_clog2(w_rate_eff);
   assign w_shift    = {w_clog, 2'b00};
   assign w_rnd      = (w_shift == 6'd0) ? '0 : (LP_ONE << (w_shift - 6'd1));
   assign w_sum      = {r_comb[3][IW-1], r_comb[3]} + w_rnd;
   assign w_shifted  = $signed(w_sum) >>> w_shift;

   always_comb begin
      w_sat = r_shf[WIDTH-1:0];
      if (!((&r_shf[IW:WIDTH-1]) || !(|r_shf[IW:WIDTH-1]))) begin
         w_sat = r_shf[IW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   always_comb begin
      w_cstage[0] = r_cin;
      for (int unsigned k = 1; k < 4; k++) w_cstage[k] = r_comb[k-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rate_q   <= '0;
         r_rate_vld <= 1'b0;
         r_cnt      <= '0;
         r_cin      <= '0;
         r_sp       <= '0;
         r_shf      <= '0;
         r_stb_out  <= 1'b0;
         r_data_out <= '0;
         for (int unsigned k = 0; k < 4; k++) begin
            r_int[k]  <= '0;
            r_cdly[k] <= '0;
            r_comb[k] <= '0;
         end
      end else begin
         r_rate_q   <= rate;
         r_rate_vld <= 1'b1;
         if (w_flush) begin
            r_cnt     <= '0;
            r_cin     <= '0;
            r_sp      <= '0;
            r_stb_out <= 1'b0;
            for (int unsigned k = 0; k < 4; k++) begin
               r_int[k]  <= '0;
               r_cdly[k] <= '0;
            end
         end else begin
            if (stb_in) begin
               r_cnt    <= w_dec ? '0 : r_cnt + 8'd1;
               r_int[0] <= r_int[0] + {{32{data_in[WIDTH-1]}}, data_in};
               for (int unsigned k = 1; k < 4; k++) r_int[k] <= r_int[k] + r_int[k-1];
               // Comb input is the last-stage value held before this update.
               if (w_dec) r_cin <= r_int[3];
            end
            r_sp <= {r_sp[4:0], w_dec};
            for (int unsigned k = 0; k < 4; k++) begin
               if (r_sp[k]) begin
                  r_cdly[k] <= w_cstage[k];
                  r_comb[k] <= w_cstage[k] - r_cdly[k];
               end
            end
            if (r_sp[4]) r_shf <= w_shifted;
            r_stb_out <= r_sp[5];
            if (r_sp[5]) r_data_out <= w_sat;
         end
      end
   end

   assign stb_out  = r_stb_out;
   assign data_out = r_data_out;

endmodule

// File: tb/tb_cic_dec_var.sv
// Directed bench for cic_dec_var: gain, impulse shape, latency, flush and reset.
// Expected values are hand-derived from the CIC difference equations.
module tb_cic_dec_var;

   logic              clk     = 1'b0;
   logic              rst_n   = 1'b0;
   logic              enable  = 1'b0;
   logic              stb_in  = 1'b0;
   logic [7:0]        rate    = 8'd1;
   logic signed [23:0] data_in = '0;
   logic              stb_out;
   logic signed [23:0] data_out;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   logic signed [23:0] outs[$];
   int                 out_cyc[$];

   cic_dec_var #(.WIDTH(24)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .rate(rate),
      .stb_in(stb_in), .data_in(data_in), .stb_out(stb_out), .data_out(data_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (stb_out === 1'b1) begin
         outs.push_back(data_out);
         out_cyc.push_back(cyc);
      end
   endtask

   task automatic do_reset(input logic [7:0] r);
      rst_n = 1'b0; enable = 1'b1; rate = r; stb_in = 1'b0; data_in = '0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      outs.delete(); out_cyc.delete(); cyc = 0;
   endtask

   task automatic feed(input logic signed [23:0] v, input int n, input int tail);
      for (int i = 0; i < n; i++) begin
         stb_in = 1'b1; data_in = v; step();
      end
      stb_in = 1'b0; data_in = '0;
      repeat (tail) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (stb_out !== 1'b0) begin fails++; $display("FAIL reset_stb: got %0b expected 0", stb_out); end
      tests++;
      if (data_out !== 24'sd0) begin fails++; $display("FAIL reset_data: got %0d expected 0", data_out); end
   endtask

   task automatic test_impulse();
      int exp_a[6] = '{0, 0, 262144, 262144, 0, 0};
      int exp_b[6] = '{0, 0, 65536, 393216, 65536, 0};
      logic signed [23:0] act;
      int adj;
      for (int pos = 0; pos < 2; pos++) begin
         do_reset(8'd2);
         for (int i = 0; i < 12; i++) begin
            stb_in = 1'b1;
            data_in = (i == pos) ? 24'sd1048576 : 24'sd0;
            step();
         end
         stb_in = 1'b0; data_in = '0;
         repeat (10) step();
         tests++;
         if (outs.size() != 6) begin fails++; $display("FAIL impulse%0d_count: got %0d expected 6", pos, outs.size()); end
         for (int k = 0; k < 6; k++) begin
            act = (k < outs.size()) ? outs[k] : 24'bx;
            tests++;
            if (act !== 24'((pos == 0) ? exp_a[k] : exp_b[k])) begin
               fails++;
               $display("FAIL impulse%0d_out%0d: got %0d expected %0d", pos, k, act, (pos == 0) ? exp_a[k] : exp_b[k]);
            end
         end
         adj = 0;
         for (int k = 1; k < out_cyc.size(); k++) if (out_cyc[k] - out_cyc[k-1] < 2) adj++;
         tests++;
         if (adj != 0) begin fails++; $display("FAIL impulse%0d_adjacent: got %0d adjacent strobes expected 0", pos, adj); end
      end
   endtask

   task automatic test_dc_gain();
      logic [7:0]         rates[6] = '{8'd4, 8'd3, 8'd8, 8'd8, 8'd0, 8'd255};
      logic signed [23:0] vals[6]  = '{24'sd1000, 24'sd1000, 24'sd8388607, -24'sd8388608, 24'sd1234, 24'sd8388607};
      logic signed [23:0] expv[6]  = '{24'sd1000, 24'sd316, 24'sd8388607, -24'sd8388608, 24'sd1234, 24'sd8258301};
      int                 nout[6]  = '{8, 8, 7, 7, 7, 30};
      int reff;
      logic signed [23:0] act;
      for (int t = 0; t < 6; t++) begin
         do_reset(rates[t]);
         reff = (rates[t] == 8'd0) ? 1 : int'(rates[t]);
         feed(vals[t], reff * nout[t], 10);
         tests++;
         if (outs.size() != nout[t]) begin
            fails++; $display("FAIL dc%0d_count: got %0d expected %0d", t, outs.size(), nout[t]);
         end
         for (int k = 4; k < nout[t]; k++) begin
            act = (k < outs.size()) ? outs[k] : 24'bx;
            tests++;
            if (act !== expv[t]) begin
               fails++; $display("FAIL dc%0d_out%0d: got %0d expected %0d", t, k, act, expv[t]);
            end
         end
      end
   endtask

   task automatic test_strobe_latency();
      int exp_c[$];
      int cnt = 0;
      int act;
      do_reset(8'd5);
      for (int i = 0; i < 50; i++) begin
         stb_in = 1'b1; data_in = 24'sd100; cnt++;
         if (cnt % 5 == 0) exp_c.push_back(cyc + 1 + 6);
         step();
         stb_in = 1'b0; step();
      end
      repeat (12) step();
      tests++;
      if (out_cyc.size() != 10) begin fails++; $display("FAIL latency_count: got %0d expected 10", out_cyc.size()); end
      for (int k = 0; k < 10; k++) begin
         act = (k < out_cyc.size()) ? out_cyc[k] : -1;
         tests++;
         if (act != exp_c[k]) begin fails++; $display("FAIL latency_out%0d: got cycle %0d expected %0d", k, act, exp_c[k]); end
      end
   endtask

   task automatic test_flush_enable();
      int expf[5] = '{0, 137, 742, 996, 1000};
      logic signed [23:0] act;
      do_reset(8'd4);
      for (int i = 0; i < 6; i++) begin stb_in = 1'b1; data_in = 24'sd1000; step(); end
      enable = 1'b0; step();
      enable = 1'b1;
      feed(24'sd1000, 20, 10);
      tests++;
      if (outs.size() != 5) begin fails++; $display("FAIL flush_en_count: got %0d expected 5", outs.size()); end
      for (int k = 0; k < 5; k++) begin
         act = (k < outs.size()) ? outs[k] : 24'bx;
         tests++;
         if (act !== 24'(expf[k])) begin fails++; $display("FAIL flush_en_out%0d: got %0d expected %0d", k, act, expf[k]); end
      end
   endtask

   task automatic test_flush_rate();
      int expr[5] = '{1, 76, 266, 316, 316};
      logic signed [23:0] act;
      do_reset(8'd4);
      for (int i = 0; i < 6; i++) begin stb_in = 1'b1; data_in = 24'sd1000; step(); end
      rate = 8'd6; step();
      feed(24'sd1000, 30, 10);
      tests++;
      if (outs.size() != 5) begin fails++; $display("FAIL flush_rate_count: got %0d expected 5", outs.size()); end
      for (int k = 0; k < 5; k++) begin
         act = (k < outs.size()) ? outs[k] : 24'bx;
         tests++;
         if (act !== 24'(expr[k])) begin fails++; $display("FAIL flush_rate_out%0d: got %0d expected %0d", k, act, expr[k]); end
      end
   endtask

   task automatic test_async_reset();
      do_reset(8'd2);
      feed(24'sd1000, 20, 0);
      tests++;
      if (data_out !== 24'sd1000) begin fails++; $display("FAIL areset_pre: got %0d expected 1000", data_out); end
      #3;
      rst_n = 1'b0;
      #1;
      tests++;
      if (stb_out !== 1'b0) begin fails++; $display("FAIL areset_stb: got %0b expected 0", stb_out); end
      tests++;
      if (data_out !== 24'sd0) begin fails++; $display("FAIL areset_data: got %0d expected 0", data_out); end
      #2;
      rst_n = 1'b1;
      outs.delete(); out_cyc.delete();
      repeat (12) step();
      tests++;
      if (outs.size() != 0) begin fails++; $display("FAIL areset_after: got %0d strobes expected 0", outs.size()); end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_dc_gain();
      test_strobe_latency();
      test_flush_enable();
      test_flush_rate();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
